// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for the 3x3 Convolutor datapath.
// Loads three kernel columns, streams image columns strip by strip, appends two
// flush pulses per strip to drain the convolver lag, and tags each output window.
// Optional feature macro: CONV_SEQ_KEEP_KERNEL_EN (adds i_keep_kernel, skips kernel load).
module conv_seq_ctrl #(
    parameter int BIT_LEN = 8,
    parameter int M_LEN   = 3,   // kernel side; only 3 is supported
    parameter int W_BITS  = 10,
    parameter int R_BITS  = 10
) (
    input  logic                     i_CLK,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [W_BITS-1:0]        i_width,
    input  logic [R_BITS-1:0]        i_strips,
`ifdef CONV_SEQ_KEEP_KERNEL_EN
    input  logic                     i_keep_kernel,
`endif
    input  logic [BIT_LEN*M_LEN-1:0] i_col_data,
    input  logic                     i_col_valid,
    output logic                     o_col_ready,
    output logic [BIT_LEN-1:0]       o_dato0,
    output logic [BIT_LEN-1:0]       o_dato1,
    output logic [BIT_LEN-1:0]       o_dato2,
    output logic                     o_selecK_I,
    output logic                     o_valid,
    input  logic                     i_out_ready,
    output logic                     o_out_valid,
    output logic                     o_out_last,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int PC_BITS = W_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_ROW,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [W_BITS-1:0]   width_q;
    logic [W_BITS-1:0]   col_cnt_q;
    logic [R_BITS-1:0]   strips_q;
    logic [PC_BITS-1:0]  pc_q;
    logic                flush_cnt_q;
    logic                qual_q;
    logic                last_q;

    logic                stall;
    logic                keep_kernel;
    logic [PC_BITS-1:0]  last_idx;
    logic                pulse_qual;
    logic                pulse_last;
    logic                kern_pulse;
    logic                img_pulse;
    logic                flush_pulse;
    logic                start_ok;
    logic                err_set;
    logic                done_set;

`ifdef CONV_SEQ_KEEP_KERNEL_EN
    assign keep_kernel = i_keep_kernel;
`else
    assign keep_kernel = 1'b0;
`endif

    // A pending window that downstream refuses blocks any further convolver shift.
    assign stall = o_out_valid && !i_out_ready;

    // Pulse k latches a complete window only for k in 4 .. width+1; width+1 is the strip's last.
    assign last_idx   = {1'b0, width_q} + PC_BITS'(1);
    assign pulse_qual = (pc_q >= PC_BITS'(4)) && (pc_q <= last_idx);
    assign pulse_last = (pc_q == last_idx);

    // State register.
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, upstream ready, and the per-cycle pulse decisions.
    always_comb begin
        state_d     = state_q;
        o_col_ready = 1'b0;
        o_busy      = (state_q != S_IDLE);
        kern_pulse  = 1'b0;
        img_pulse   = 1'b0;
        flush_pulse = 1'b0;
        start_ok    = 1'b0;
        err_set     = 1'b0;
        done_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if ((i_width < W_BITS'(3)) || (i_strips == '0)) begin
                        err_set = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_d  = keep_kernel ? S_ROW : S_KLOAD;
                    end
                end
            end
            S_KLOAD: begin
                o_col_ready = 1'b1;
                if (i_col_valid) begin
                    kern_pulse = 1'b1;
                    if (col_cnt_q == W_BITS'(2)) begin
                        state_d = S_ROW;
                    end
                end
            end
            S_ROW: begin
                o_col_ready = !stall;
                if (i_col_valid && !stall) begin
                    img_pulse = 1'b1;
                    if (col_cnt_q == width_q - W_BITS'(1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (!stall) begin
                    flush_pulse = 1'b1;
                    if (flush_cnt_q) begin
                        state_d = (strips_q > R_BITS'(1)) ? S_ROW : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Wait for the final flush pulse to land and its window to be taken.
                if (!o_valid && (!o_out_valid || i_out_ready)) begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered convolver drive: one shift pulse per accepted beat or flush slot.
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            o_valid    <= 1'b0;
            o_selecK_I <= 1'b0;
            o_dato0    <= '0;
            o_dato1    <= '0;
            o_dato2    <= '0;
            o_err      <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_valid <= kern_pulse | img_pulse | flush_pulse;
            o_err   <= err_set;
            o_done  <= done_set;
            if (kern_pulse || img_pulse) begin
                o_selecK_I <= img_pulse;
                o_dato0    <= i_col_data[BIT_LEN-1:0];
                o_dato1    <= i_col_data[2*BIT_LEN-1:BIT_LEN];
                o_dato2    <= i_col_data[3*BIT_LEN-1:2*BIT_LEN];
            end else if (flush_pulse) begin
                o_selecK_I <= 1'b1;
                o_dato0    <= '0;
                o_dato1    <= '0;
                o_dato2    <= '0;
            end
        end
    end

    // Frame bookkeeping: latched geometry, column/pulse counters and strip countdown.
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            width_q     <= '0;
            strips_q    <= '0;
            col_cnt_q   <= '0;
            pc_q        <= '0;
            flush_cnt_q <= 1'b0;
            qual_q      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            qual_q <= 1'b0;
            last_q <= 1'b0;
            if (start_ok) begin
                width_q     <= i_width;
                strips_q    <= i_strips;
                col_cnt_q   <= '0;
                pc_q        <= '0;
                flush_cnt_q <= 1'b0;
            end
            if (kern_pulse) begin
                col_cnt_q <= (col_cnt_q == W_BITS'(2)) ? '0 : col_cnt_q + W_BITS'(1);
            end
            if (img_pulse) begin
                col_cnt_q <= (col_cnt_q == width_q - W_BITS'(1)) ? '0 : col_cnt_q + W_BITS'(1);
            end
            if (img_pulse || flush_pulse) begin
                pc_q   <= pc_q + PC_BITS'(1);
                qual_q <= pulse_qual;
                last_q <= pulse_last;
            end
            if (flush_pulse) begin
                flush_cnt_q <= ~flush_cnt_q;
                if (flush_cnt_q) begin
                    pc_q <= '0;
                    if (strips_q > R_BITS'(1)) begin
                        strips_q <= strips_q - R_BITS'(1);
                    end
                end
            end
        end
    end

    // Output tagging: a qualifying pulse raises valid/last; only a handshake clears them.
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
        end else if (o_valid && qual_q) begin
            o_out_valid <= 1'b1;
            o_out_last  <= last_q;
        end else if (o_out_valid && i_out_ready) begin
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: directed, table-driven bench for conv_seq_ctrl.
module tb_conv_seq_ctrl;

    localparam int BIT_LEN = 8;
    localparam int M_LEN   = 3;
    localparam int W_BITS  = 10;
    localparam int R_BITS  = 10;

    logic                     i_CLK = 1'b0;
    logic                     i_reset;
    logic                     i_start;
    logic [W_BITS-1:0]        i_width;
    logic [R_BITS-1:0]        i_strips;
`ifdef CONV_SEQ_KEEP_KERNEL_EN
    logic                     i_keep_kernel;
`endif
    logic [BIT_LEN*M_LEN-1:0] i_col_data;
    logic                     i_col_valid;
    logic                     o_col_ready;
    logic [BIT_LEN-1:0]       o_dato0;
    logic [BIT_LEN-1:0]       o_dato1;
    logic [BIT_LEN-1:0]       o_dato2;
    logic                     o_selecK_I;
    logic                     o_valid;
    logic                     i_out_ready;
    logic                     o_out_valid;
    logic                     o_out_last;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_err;

    typedef struct {
        int width;
        int strips;
        bit keep;
        bit poke;
        int exp_k;
        int exp_i;
        int exp_win;
        int exp_last;
        int exp_lat;
    } vec_t;

    vec_t vecs[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_k, n_i, n_win, n_last, n_done, n_err, done_cyc;
    logic       prev_xfer = 1'b0;
    logic [23:0] prev_data = '0;
    logic [7:0] dcnt = 8'd1;
    logic [23:0] held;

    conv_seq_ctrl #(
        .BIT_LEN(BIT_LEN),
        .M_LEN  (M_LEN),
        .W_BITS (W_BITS),
        .R_BITS (R_BITS)
    ) dut (
        .i_CLK        (i_CLK),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_width      (i_width),
        .i_strips     (i_strips),
`ifdef CONV_SEQ_KEEP_KERNEL_EN
        .i_keep_kernel(i_keep_kernel),
`endif
        .i_col_data   (i_col_data),
        .i_col_valid  (i_col_valid),
        .o_col_ready  (o_col_ready),
        .o_dato0      (o_dato0),
        .o_dato1      (o_dato1),
        .o_dato2      (o_dato2),
        .o_selecK_I   (o_selecK_I),
        .o_valid      (o_valid),
        .i_out_ready  (i_out_ready),
        .o_out_valid  (o_out_valid),
        .o_out_last   (o_out_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_CLK = ~i_CLK;

    always @(posedge i_CLK) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Advance to just after the next rising edge and present a fresh column pattern.
    task automatic tick();
        @(posedge i_CLK);
        #1;
        dcnt       = dcnt + 8'd3;
        i_col_data = {dcnt + 8'd2, dcnt + 8'd1, dcnt};
    endtask

    task automatic clear_counts();
        n_k = 0; n_i = 0; n_win = 0; n_last = 0; n_done = 0; n_err = 0; done_cyc = 0;
    endtask

    // Mid-cycle monitor: pulse accounting, window handshakes and pulse data against the beat taken.
    always @(negedge i_CLK) begin
        if (!i_reset) begin
            prev_xfer = 1'b0;
        end else begin
            if (prev_xfer) check_output("pulse_after_xfer", 32'(o_valid), 32'd1);
            if (o_valid) begin
                if (o_selecK_I) n_i++; else n_k++;
                check_output("pulse_data", 32'({o_dato2, o_dato1, o_dato0}),
                             prev_xfer ? 32'(prev_data) : 32'd0);
            end
            if (o_out_valid && i_out_ready) begin
                n_win++;
                if (o_out_last) n_last++;
            end
            if (o_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (o_err) n_err++;
            prev_xfer = i_col_valid && o_col_ready;
            prev_data = i_col_data;
        end
    end

    // Run one complete frame with upstream always valid and downstream always ready.
    task automatic apply_stimulus(input vec_t v);
        int start_cyc;
        clear_counts();
        i_col_valid = 1'b1;
        i_out_ready = 1'b1;
        i_width     = W_BITS'(v.width);
        i_strips    = R_BITS'(v.strips);
`ifdef CONV_SEQ_KEEP_KERNEL_EN
        i_keep_kernel = v.keep;
`endif
        i_start   = 1'b1;
        start_cyc = cyc;
        tick();
        i_start = 1'b0;
        check_output("busy_in_frame", 32'(o_busy), 32'd1);
        for (int t = 0; t < 4000 && n_done == 0; t++) begin
            if (v.poke && t == 4) begin
                i_start = 1'b1;
                i_width = W_BITS'(2);
            end else if (v.poke && t == 5) begin
                i_start = 1'b0;
                i_width = W_BITS'(v.width);
            end
            tick();
        end
        repeat (4) tick();
        check_output("kernel_pulses", n_k, v.exp_k);
        check_output("image_pulses", n_i, v.exp_i);
        check_output("windows", n_win, v.exp_win);
        check_output("last_flags", n_last, v.exp_last);
        check_output("done_count", n_done, 1);
        check_output("err_in_frame", n_err, 0);
        check_output("latency", done_cyc - start_cyc, v.exp_lat);
        check_output("busy_after", 32'(o_busy), 32'd0);
        i_col_valid = 1'b0;
`ifdef CONV_SEQ_KEEP_KERNEL_EN
        i_keep_kernel = 1'b0;
`endif
    endtask

    initial begin
        i_reset     = 1'b0;
        i_start     = 1'b0;
        i_width     = '0;
        i_strips    = '0;
        i_col_valid = 1'b0;
        i_col_data  = '0;
        i_out_ready = 1'b1;
`ifdef CONV_SEQ_KEEP_KERNEL_EN
        i_keep_kernel = 1'b0;
`endif
        clear_counts();

        // width, strips, keep, poke, kernel, image, windows, lasts, latency
        vecs.push_back('{5, 1, 1'b0, 1'b0, 3, 7, 3, 1, 13});
        vecs.push_back('{4, 3, 1'b0, 1'b0, 3, 18, 6, 3, 24});
        vecs.push_back('{3, 1, 1'b0, 1'b0, 3, 5, 1, 1, 11});
        vecs.push_back('{3, 2, 1'b0, 1'b0, 3, 10, 2, 2, 16});
        vecs.push_back('{8, 2, 1'b0, 1'b0, 3, 20, 12, 2, 26});
        vecs.push_back('{6, 1, 1'b0, 1'b1, 3, 8, 4, 1, 14});
`ifdef CONV_SEQ_KEEP_KERNEL_EN
        vecs.push_back('{5, 1, 1'b1, 1'b0, 0, 7, 3, 1, 10});
        vecs.push_back('{4, 1, 1'b0, 1'b0, 3, 6, 2, 1, 12});
`endif

        // Reset state
        repeat (3) tick();
        check_output("rst_valid", 32'(o_valid), 32'd0);
        check_output("rst_col_ready", 32'(o_col_ready), 32'd0);
        check_output("rst_busy", 32'(o_busy), 32'd0);
        check_output("rst_out_valid", 32'(o_out_valid), 32'd0);
        check_output("rst_out_last", 32'(o_out_last), 32'd0);
        check_output("rst_done", 32'(o_done), 32'd0);
        check_output("rst_err", 32'(o_err), 32'd0);
        check_output("rst_selec", 32'(o_selecK_I), 32'd0);
        check_output("rst_data", 32'({o_dato2, o_dato1, o_dato0}), 32'd0);
        i_reset = 1'b1;
        tick();

        // Rejected starts: width below 3, then zero strips
        clear_counts();
        i_width  = W_BITS'(2);
        i_strips = R_BITS'(1);
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        check_output("err_w2_pulse", 32'(o_err), 32'd1);
        check_output("err_w2_busy", 32'(o_busy), 32'd0);
        tick();
        check_output("err_w2_one_cycle", 32'(o_err), 32'd0);
        i_width  = W_BITS'(5);
        i_strips = R_BITS'(0);
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        check_output("err_s0_pulse", 32'(o_err), 32'd1);
        check_output("err_s0_busy", 32'(o_busy), 32'd0);
        tick();
        check_output("err_total", n_err, 2);
        check_output("err_busy_after", 32'(o_busy), 32'd0);

        // Table of complete frames
        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Backpressure: hold downstream off for 10 cycles once the first window is out
        clear_counts();
        i_col_valid = 1'b1;
        i_out_ready = 1'b1;
        i_width     = W_BITS'(8);
        i_strips    = R_BITS'(1);
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (7) tick();
        tick();
        i_col_valid = 1'b0;
        i_out_ready = 1'b0;
        tick();
        i_col_valid = 1'b1;
        check_output("stall_first_window", 32'(o_out_valid), 32'd1);
        held = {o_dato2, o_dato1, o_dato0};
        for (int s = 0; s < 10; s++) begin
            check_output("stall_col_ready", 32'(o_col_ready), 32'd0);
            check_output("stall_no_pulse", 32'(o_valid), 32'd0);
            check_output("stall_data_hold", 32'({o_dato2, o_dato1, o_dato0}), 32'(held));
            tick();
        end
        i_out_ready = 1'b1;
        for (int t = 0; t < 4000 && n_done == 0; t++) tick();
        repeat (4) tick();
        check_output("stall_kernel_pulses", n_k, 3);
        check_output("stall_image_pulses", n_i, 10);
        check_output("stall_windows", n_win, 6);
        check_output("stall_lasts", n_last, 1);
        check_output("stall_done", n_done, 1);
        i_col_valid = 1'b0;

        // Reset asserted at the fifth image beat of a width-8 strip
        clear_counts();
        i_col_valid = 1'b1;
        i_width     = W_BITS'(8);
        i_strips    = R_BITS'(1);
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (7) tick();
        check_output("abort_busy_before", 32'(o_busy), 32'd1);
        i_reset = 1'b0;
        #1;
        check_output("abort_valid", 32'(o_valid), 32'd0);
        check_output("abort_col_ready", 32'(o_col_ready), 32'd0);
        check_output("abort_busy", 32'(o_busy), 32'd0);
        check_output("abort_out_valid", 32'(o_out_valid), 32'd0);
        check_output("abort_selec", 32'(o_selecK_I), 32'd0);
        check_output("abort_data", 32'({o_dato2, o_dato1, o_dato0}), 32'd0);
        tick();
        check_output("abort_busy_next", 32'(o_busy), 32'd0);
        check_output("abort_no_done", n_done, 0);
        i_reset = 1'b1;
        tick();
        apply_stimulus('{8, 1, 1'b0, 1'b0, 3, 10, 6, 1, 16});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
